// File: rtl/nios_system_hex_pwm.sv
// Multi-channel Avalon-MM display output with PWM brightness, per-channel blink, enable and inversion.
// Optional feature macro HEX_PWM_EN adds the PWM counter, DUTY register and STATUS bit1.
module nios_system_hex_pwm #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 8,
  parameter int PWM_W     = 8,
  parameter int BLINK_DIV = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic                     read_n,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  output logic [NUM_CH*DATA_W-1:0] out_port
);

  logic [DATA_W-1:0]        data_q [NUM_CH];
  logic [NUM_CH-1:0]        mask_q;
  logic                     en_q;
  logic                     inv_q;
  logic [BLINK_DIV-1:0]     blink_cnt_q;
  logic [31:0]              readdata_q, readdata_d;
  logic [NUM_CH*DATA_W-1:0] out_q, out_d;
  logic                     pwm_on;
  logic                     blink_phase;
  logic                     wr_en;
  logic                     rd_en;
  logic                     unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign rd_en        = chipselect & ~read_n;
  assign blink_phase  = blink_cnt_q[BLINK_DIV-1];
  assign unused_wdata = ^writedata;

`ifdef HEX_PWM_EN
  logic [PWM_W-1:0] pwm_cnt_q;
  logic [PWM_W-1:0] duty_q;

  // All-ones duty is a full-on override; otherwise on for DUTY counts from cnt=0.
  assign pwm_on = (&duty_q) | (pwm_cnt_q < duty_q);
`else
  assign pwm_on = 1'b1;
`endif

  always_comb begin
    out_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      logic vis;
      vis = en_q & pwm_on & ~(mask_q[i] & blink_phase);
      out_d[i*DATA_W +: DATA_W] = (vis ? data_q[i] : '0) ^ {DATA_W{inv_q}};
    end
  end

  // Read mux uses pre-write register values, so same-cycle read/write returns old data.
  always_comb begin
    readdata_d = readdata_q;
    if (rd_en) begin
      readdata_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (address == 4'(i)) readdata_d[DATA_W-1:0] = data_q[i];
      end
      case (address)
`ifdef HEX_PWM_EN
        4'd8:    readdata_d[PWM_W-1:0] = duty_q;
`endif
        4'd9:    readdata_d[NUM_CH-1:0] = mask_q;
        4'd10:   readdata_d[1:0] = {inv_q, en_q};
        4'd11:   readdata_d[1:0] = {pwm_on, blink_phase};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) data_q[i] <= '0;
      mask_q      <= '0;
      en_q        <= 1'b1;
      inv_q       <= 1'b0;
      blink_cnt_q <= '0;
      readdata_q  <= '0;
      out_q       <= '0;
`ifdef HEX_PWM_EN
      pwm_cnt_q   <= '0;
      duty_q      <= '1;
`endif
    end else begin
      blink_cnt_q <= blink_cnt_q + BLINK_DIV'(1);
      readdata_q  <= readdata_d;
      out_q       <= out_d;
`ifdef HEX_PWM_EN
      pwm_cnt_q   <= pwm_cnt_q + PWM_W'(1);
      if (wr_en && address == 4'd8) duty_q <= writedata[PWM_W-1:0];
`endif
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_en && address == 4'(i)) data_q[i] <= writedata[DATA_W-1:0];
      end
      if (wr_en && address == 4'd9) mask_q <= writedata[NUM_CH-1:0];
      if (wr_en && address == 4'd10) begin
        en_q  <= writedata[0];
        inv_q <= writedata[1];
      end
    end
  end

  assign readdata = readdata_q;
  assign out_port = out_q;

endmodule

// File: tb/tb_nios_system_hex_pwm.sv
// Scoreboard bench for nios_system_hex_pwm: reference model pushes expected pins/readdata per edge, monitor compares.
module tb_nios_system_hex_pwm;
  localparam int NUM_CH    = 4;
  localparam int DATA_W    = 8;
  localparam int PWM_W     = 8;
  localparam int BLINK_DIV = 4;
  localparam int HALF      = 1 << (BLINK_DIV - 1);
  localparam int PERIOD    = 1 << PWM_W;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic [3:0]               address = '0;
  logic                     chipselect = 1'b0;
  logic                     write_n = 1'b1;
  logic                     read_n = 1'b1;
  logic [31:0]              writedata = '0;
  logic [31:0]              readdata;
  logic [NUM_CH*DATA_W-1:0] out_port;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [NUM_CH*DATA_W-1:0] out;
    logic [31:0]              rd;
  } exp_t;
  exp_t sb_q[$];

  int          m_data [NUM_CH];
  int          m_duty;
  int          m_mask;
  bit          m_en;
  bit          m_inv;
  longint      m_t;
  logic [NUM_CH*DATA_W-1:0] m_out;
  logic [31:0] m_rd;

  nios_system_hex_pwm #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .PWM_W(PWM_W), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata),
    .readdata(readdata), .out_port(out_port)
  );

  always #5 clk = ~clk;

  function automatic bit model_pwm_on();
`ifdef HEX_PWM_EN
    return (m_duty == PERIOD - 1) || (int'(m_t % PERIOD) < m_duty);
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit model_phase();
    return ((m_t / HALF) % 2) == 1;
  endfunction

  function automatic int model_read(input int a);
    if (a < NUM_CH) return m_data[a];
`ifdef HEX_PWM_EN
    if (a == 8) return m_duty;
`endif
    if (a == 9) return m_mask;
    if (a == 10) return (m_inv ? 2 : 0) + (m_en ? 1 : 0);
    if (a == 11) return (model_pwm_on() ? 2 : 0) + (model_phase() ? 1 : 0);
    return 0;
  endfunction

  // Drive one cycle, advance the model across the coming edge, queue the expected result.
  task automatic step(input bit rst, input bit cs, input bit wn, input bit rn,
                      input int a, input logic [31:0] wd);
    @(negedge clk);
    reset = rst; chipselect = cs; write_n = wn; read_n = rn;
    address = 4'(a); writedata = wd;
    if (rst) begin
      foreach (m_data[i]) m_data[i] = 0;
      m_duty = PERIOD - 1; m_mask = 0; m_en = 1; m_inv = 0; m_t = 0;
      m_out = '0; m_rd = '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        bit vis;
        int ch;
        vis = m_en && model_pwm_on() && !(((m_mask >> i) & 1) == 1 && model_phase());
        ch = vis ? m_data[i] : 0;
        if (m_inv) ch = ch ^ ((1 << DATA_W) - 1);
        m_out[i*DATA_W +: DATA_W] = DATA_W'(ch);
      end
      if (cs && !rn) m_rd = 32'(model_read(a));
      if (cs && !wn) begin
        if (a < NUM_CH) m_data[a] = int'(wd) & ((1 << DATA_W) - 1);
`ifdef HEX_PWM_EN
        if (a == 8) m_duty = int'(wd) & (PERIOD - 1);
`endif
        if (a == 9) m_mask = int'(wd) & ((1 << NUM_CH) - 1);
        if (a == 10) begin m_en = wd[0]; m_inv = wd[1]; end
      end
      m_t++;
    end
    sb_q.push_back('{out: m_out, rd: m_rd});
    @(posedge clk);
  endtask

  task automatic idle();     step(0, 0, 1, 1, 0, 32'h0); endtask
  task automatic wr(input int a, input logic [31:0] d); step(0, 1, 0, 1, a, d); endtask
  task automatic rd(input int a); step(0, 1, 1, 0, a, 32'h0); endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic count_on(input int n, input int ch, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      idle();
      #1;
      if (out_port[ch*DATA_W +: DATA_W] != '0) cnt++;
    end
  endtask

  // Monitor: every edge produces pins and readdata; pop and compare.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks += 2;
      if (out_port !== e.out) begin
        errors++;
        $display("FAIL out_port @%0t got=%h expected=%h", $time, out_port, e.out);
      end
      if (readdata !== e.rd) begin
        errors++;
        $display("FAIL readdata @%0t got=%h expected=%h", $time, readdata, e.rd);
      end
    end
  end

  initial begin
    int c;
    step(1, 0, 1, 1, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    rd(10);
    rd(8);
    rd(11);
    wr(2, 32'hFFFF_FFA5);
    idle();
    rd(2);
    rd(5);
    rd(13);
    wr(13, 32'h1234);
    idle();

    for (int k = 0; k < 1500; k++) begin
      bit r, cs, wn, rn;
      r  = ($urandom_range(0, 299) == 0);
      cs = ($urandom_range(0, 3) != 0);
      wn = ($urandom_range(0, 2) != 0);
      rn = ($urandom_range(0, 1) != 0);
      step(r, cs, wn, rn, int'($urandom_range(0, 15)), $urandom);
    end

    step(1, 0, 1, 1, 0, 0);
    step(1, 1, 1, 0, 10, 0);
    step(1, 1, 0, 1, 0, 32'hFF);
    rd(10);
    rd(8);

    wr(0, 32'hFF);
    wr(8, 32'h40);
    count_on(PERIOD, 0, c);
`ifdef HEX_PWM_EN
    chk("pwm_duty40_on_cycles", c, 64);
`else
    chk("pwm_duty40_on_cycles", c, PERIOD);
`endif
    rd(11);
    wr(8, 32'h0);
    count_on(PERIOD, 0, c);
`ifdef HEX_PWM_EN
    chk("pwm_duty0_on_cycles", c, 0);
`else
    chk("pwm_duty0_on_cycles", c, PERIOD);
`endif
    rd(8);
    rd(11);
    wr(8, 32'hFF);
    count_on(PERIOD, 0, c);
    chk("pwm_dutyff_on_cycles", c, PERIOD);

    wr(9, 32'h2);
    wr(1, 32'h3C);
    count_on(4 * HALF, 1, c);
    chk("blink_ch1_on_cycles", c, 2 * HALF);
    count_on(4 * HALF, 0, c);
    chk("blink_ch0_unaffected", c, 4 * HALF);
    rd(11);

    wr(9, 32'h0);
    wr(10, 32'h2);
    idle();
    #1;
    chk("en0_inv1_all_ones", int'(out_port), -1);
    wr(3, 32'h0F);
    wr(10, 32'h3);
    idle();
    #1;
    chk("inv_ch3", int'(out_port[3*DATA_W +: DATA_W]), 8'hF0);
    rd(10);
    wr(10, 32'h1);
    step(0, 1, 0, 0, 3, 32'h77);
    rd(3);
    idle();
    idle();
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
